// File: rtl/dmem_responder.sv
// dmem_responder: one-request-at-a-time load/store responder with a fixed
// latency over a word-addressed 64-bit backing array.
module dmem_responder #(
    parameter int DEPTH   = 4096,
    parameter int LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        opload_index_valid,
    input  logic [18:0] opload_index,
    output logic        opload_index_ready,
    output logic [63:0] opload_read_data,
    output logic        opload_operation_done,
    input  logic        opstore_index_valid,
    input  logic [18:0] opstore_index,
    input  logic [63:0] opstore_write_data,
    input  logic [63:0] opstore_write_mask,
    output logic        opstore_index_ready,
    output logic        opstore_operation_done,
    output logic        busy
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state, state_nxt;
    logic [3:0]    cnt, cnt_nxt;
    logic          accept, fire, in_range;
    logic          is_store;
    logic [18:0]   idx;
    logic [63:0]   wdata, wmask;
    logic [AW-1:0] addr;
    logic [63:0]   mem [DEPTH];

    assign in_range = {1'b0, idx} < 20'(DEPTH);
    assign addr     = idx[AW-1:0];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        fire      = 1'b0;
        unique case (state)
            IDLE: begin
                if (opload_index_valid || opstore_index_valid) begin
                    accept    = 1'b1;
                    state_nxt = WAIT;
                    cnt_nxt   = 4'(LATENCY - 1);
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    fire      = 1'b1;
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= IDLE;
            cnt              <= '0;
            opload_read_data <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (fire && !is_store) begin
                opload_read_data <= in_range ? mem[addr] : '0;
            end
        end
    end

    // Store wins a tie; the load initiator keeps valid high and retries.
    always_ff @(posedge clock) begin
        if (accept) begin
            is_store <= opstore_index_valid;
            idx      <= opstore_index_valid ? opstore_index : opload_index;
            wdata    <= opstore_write_data;
            wmask    <= opstore_write_mask;
        end
    end

    always_ff @(posedge clock) begin
        if (fire && is_store && in_range && !reset) begin
            mem[addr] <= (mem[addr] & ~wmask) | (wdata & wmask);
        end
    end

    assign opload_index_ready     = (state == IDLE);
    assign opstore_index_ready    = (state == IDLE);
    assign busy                   = (state != IDLE);
    assign opload_operation_done  = (state == RESP) && !is_store;
    assign opstore_operation_done = (state == RESP) && is_store;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: three instances with LATENCY 2, 4
// and 1; expected responses are queued at issue and checked on done.
module tb_dmem_responder;

    typedef struct {
        int          k;
        bit          st;
        logic [63:0] d;
        longint      cyc;
    } exp_t;

    logic        clk = 1'b0;
    longint      cyc = 0;
    int          tests = 0;
    int          errors = 0;
    exp_t        q[$];

    logic        rst [3];
    logic        lv  [3];
    logic        sv  [3];
    logic        lr  [3];
    logic        sr  [3];
    logic        ld  [3];
    logic        sd  [3];
    logic        bz  [3];
    logic [18:0] li  [3];
    logic [18:0] si  [3];
    logic [63:0] rd  [3];
    logic [63:0] wd  [3];
    logic [63:0] wm  [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_responder #(
            .DEPTH(4096),
            .LATENCY(g == 0 ? 2 : (g == 1 ? 4 : 1))
        ) u (
            .clock(clk),
            .reset(rst[g]),
            .opload_index_valid(lv[g]),
            .opload_index(li[g]),
            .opload_index_ready(lr[g]),
            .opload_read_data(rd[g]),
            .opload_operation_done(ld[g]),
            .opstore_index_valid(sv[g]),
            .opstore_index(si[g]),
            .opstore_write_data(wd[g]),
            .opstore_write_mask(wm[g]),
            .opstore_index_ready(sr[g]),
            .opstore_operation_done(sd[g]),
            .busy(bz[g])
        );
    end

    function automatic int lat(int k);
        return (k == 0) ? 2 : ((k == 1) ? 4 : 1);
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (ld[k] || sd[k]) begin
                    tests++;
                    if (ld[k] && sd[k]) begin
                        errors++;
                        $display("FAIL both_done dut%0d at cycle %0d", k, cyc);
                    end else if (q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_done dut%0d st=%0d cycle %0d",
                                 k, sd[k], cyc);
                    end else begin
                        e = q.pop_front();
                        if (e.k != k || e.st != sd[k] || e.cyc != cyc ||
                            (!e.st && rd[k] !== e.d)) begin
                            errors++;
                            $display("FAIL response dut%0d: got st=%0d cyc=%0d data=%h expected dut%0d st=%0d cyc=%0d data=%h",
                                     k, sd[k], cyc, rd[k], e.k, e.st, e.cyc, e.d);
                        end
                    end
                end
            end
        end
    endtask

    task automatic push(int k, bit st, logic [63:0] d, longint c);
        exp_t e;
        e.k = k; e.st = st; e.d = d; e.cyc = c;
        q.push_back(e);
    endtask

    task automatic issue(int k, bit st, logic [18:0] idx, logic [63:0] d,
                         logic [63:0] m, logic [63:0] exp, bit win);
        int n = 0;
        if (st) begin
            si[k] = idx; wd[k] = d; wm[k] = m; sv[k] = 1'b1;
        end else begin
            li[k] = idx; lv[k] = 1'b1;
        end
        while (!(st ? sr[k] : lr[k]) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            tests++;
            errors++;
            $display("FAIL accept_timeout dut%0d st=%0d", k, st);
        end
        push(k, st, exp, cyc + 1 + lat(k));
        @(negedge clk);
        sv[k] = 1'b0;
        lv[k] = 1'b0;
        if (win) begin
            for (int i = 0; i <= lat(k); i++) begin
                check($sformatf("ready_busy dut%0d i%0d", k, i),
                      {62'd0, lr[k], sr[k]}, 64'd0);
                @(negedge clk);
            end
            check($sformatf("ready_back dut%0d", k), {62'd0, lr[k], sr[k]}, 64'd3);
        end
    endtask

    localparam logic [63:0] ONES = '1;

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; lv[k] = 1'b0; sv[k] = 1'b0;
            li[k] = '0; si[k] = '0; wd[k] = '0; wm[k] = '0;
        end
        fork
            monitor();
        join_none
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_done dut%0d", k), {62'd0, ld[k], sd[k]}, 64'd0);
            check($sformatf("rst_busy dut%0d", k), {63'd0, bz[k]}, 64'd0);
            check($sformatf("rst_rdata dut%0d", k), rd[k], 64'd0);
        end
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;
        @(negedge clk);
        check("ready_after_reset", {62'd0, lr[0], sr[0]}, 64'd3);

        // store then load back, full mask
        issue(0, 1, 19'd5, 64'h1122334455667788, ONES, 0, 1);
        issue(0, 0, 19'd5, 0, 0, 64'h1122334455667788, 1);

        // partial mask
        issue(0, 1, 19'd7, ONES, ONES, 0, 1);
        issue(0, 1, 19'd7, 64'd0, 64'h0000_0000_FFFF_0000, 0, 1);
        issue(0, 0, 19'd7, 0, 0, 64'hFFFF_FFFF_0000_FFFF, 1);

        // simultaneous load and store to idx 3: store first
        li[0] = 19'd3; lv[0] = 1'b1;
        si[0] = 19'd3; wd[0] = 64'hAB; wm[0] = ONES; sv[0] = 1'b1;
        push(0, 1, 0, cyc + 1 + 2);
        @(negedge clk);
        sv[0] = 1'b0;
        for (int i = 0; i <= 2; i++) begin
            check($sformatf("tie_ready_busy i%0d", i), {62'd0, lr[0], sr[0]}, 64'd0);
            @(negedge clk);
        end
        check("tie_ready_back", {63'd0, lr[0]}, 64'd1);
        push(0, 0, 64'hAB, cyc + 1 + 2);
        @(negedge clk);
        lv[0] = 1'b0;
        repeat (4) @(negedge clk);

        // out of range
        issue(0, 1, 19'd904, 64'hCAFE, ONES, 0, 1);
        issue(0, 0, 19'd5000, 0, 0, 64'd0, 1);
        issue(0, 1, 19'd5000, 64'hDEAD, ONES, 0, 1);
        issue(0, 0, 19'd904, 0, 0, 64'hCAFE, 1);
        issue(0, 0, 19'd5000, 0, 0, 64'd0, 1);

        // reset during WAIT drops the store (LATENCY 4)
        issue(1, 1, 19'd9, 64'h9999, ONES, 0, 1);
        si[1] = 19'd9; wd[1] = 64'h5555; wm[1] = ONES; sv[1] = 1'b1;
        @(negedge clk);
        sv[1] = 1'b0;
        rst[1] = 1'b1;
        @(negedge clk);
        rst[1] = 1'b0;
        check("abort_ready_now", {62'd0, lr[1], sr[1]}, 64'd3);
        @(negedge clk);
        check("abort_ready_next", {62'd0, lr[1], sr[1]}, 64'd3);
        check("abort_busy", {63'd0, bz[1]}, 64'd0);
        repeat (6) @(negedge clk);
        issue(1, 0, 19'd9, 0, 0, 64'h9999, 1);

        // LATENCY 1: hold of read data and back-to-back loads
        issue(2, 1, 19'd1, 64'hA1, ONES, 0, 1);
        issue(2, 1, 19'd2, 64'hB2, ONES, 0, 1);
        issue(2, 0, 19'd1, 0, 0, 64'hA1, 1);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("hold_idle i%0d", i), rd[2], 64'hA1);
            @(negedge clk);
        end
        issue(2, 1, 19'd1, 64'hC3, ONES, 0, 1);
        check("hold_after_store", rd[2], 64'hA1);
        issue(2, 0, 19'd2, 0, 0, 64'hB2, 0);
        issue(2, 0, 19'd1, 0, 0, 64'hC3, 0);

        repeat (10) @(negedge clk);
        check("queue_drained", 64'(q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
